// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, redirect
// source codes (numerically ordered by priority) and default vectors.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HOLD = 2'd2,
        FS_HALT = 2'd3
    } fs_state_t;

    // Larger code means higher priority.
    typedef enum logic [1:0] {
        RS_JMP  = 2'd0,
        RS_BR   = 2'd1,
        RS_ERET = 2'd2,
        RS_EXC  = 2'd3
    } redir_src_t;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

    function automatic logic prio_wins(input redir_src_t new_src, input redir_src_t held_src);
        return (new_src == RS_EXC) || (new_src > held_src);
    endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// Combinational priority mux over the redirect sources: exc > eret > br > jmp.
module redirect_arbiter
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        req_valid,
    output redir_src_t  req_prio,
    output logic [31:0] req_target
);

    always_comb begin
        req_valid  = 1'b0;
        req_prio   = RS_JMP;
        req_target = jmp_target;
        if (exc_valid) begin
            req_valid  = 1'b1;
            req_prio   = RS_EXC;
            req_target = EXC_VEC;
        end else if (eret_valid) begin
            req_valid  = 1'b1;
            req_prio   = RS_ERET;
            req_target = epc;
        end else if (br_valid) begin
            req_valid  = 1'b1;
            req_prio   = RS_BR;
            req_target = br_target;
        end else if (jmp_valid) begin
            req_valid  = 1'b1;
            req_prio   = RS_JMP;
            req_target = jmp_target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: boots the PC, issues arbitrated redirects one cycle
// after they are seen, parks a redirect across a stall and stops on halt.
//
//  state | meaning
//  BOOT  | fetch paused, reset vector loaded, boot counter running
//  RUN   | normal fetch, redirects issued next cycle
//  HOLD  | redirect parked in pending register until stall clears
//  HALT  | fetch stopped until reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEF,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_exc_valid,
    input  logic        i_eret_valid,
    input  logic [31:0] i_epc,
    input  logic        i_br_valid,
    input  logic [31:0] i_br_target,
    input  logic        i_jmp_valid,
    input  logic [31:0] i_jmp_target,
    input  logic        i_halt,
    output logic        o_pause,
    output logic        o_we,
    output logic [31:0] o_PC,
    output logic        o_flush,
    output logic [1:0]  o_state
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    fs_state_t        state_q, state_nx;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_nx;
    redir_src_t       pend_prio_q, pend_prio_nx;
    logic [31:0]      pend_target_q, pend_target_nx;

    logic        req_valid;
    redir_src_t  req_prio;
    logic [31:0] req_target;

    logic        issue, issue_flush;
    logic [31:0] issue_pc;
    redir_src_t  sel_prio;
    logic [31:0] sel_target;

    redirect_arbiter #(.EXC_VEC(EXC_VEC)) u_arb (
        .exc_valid  (i_exc_valid),
        .eret_valid (i_eret_valid),
        .epc        (i_epc),
        .br_valid   (i_br_valid),
        .br_target  (i_br_target),
        .jmp_valid  (i_jmp_valid),
        .jmp_target (i_jmp_target),
        .req_valid  (req_valid),
        .req_prio   (req_prio),
        .req_target (req_target)
    );

    always_comb begin
        state_nx       = state_q;
        boot_cnt_nx    = boot_cnt_q;
        pend_prio_nx   = pend_prio_q;
        pend_target_nx = pend_target_q;
        issue          = 1'b0;
        issue_flush    = 1'b0;
        issue_pc       = req_target;
        sel_prio       = pend_prio_q;
        sel_target     = pend_target_q;

        case (state_q)
            FS_BOOT: begin
                if (boot_cnt_q == '0) begin
                    issue    = 1'b1;
                    issue_pc = RESET_VEC;
                end
                if (boot_cnt_q == BOOT_LAST) state_nx = FS_RUN;
                else                         boot_cnt_nx = boot_cnt_q + CNT_W'(1);
            end
            FS_RUN, FS_HOLD: begin
                if (i_halt) begin
                    // An exception still goes out even when halt retires alongside it.
                    if (req_valid && req_prio == RS_EXC) begin
                        issue       = 1'b1;
                        issue_flush = 1'b1;
                    end
                    pend_prio_nx   = RS_JMP;
                    pend_target_nx = '0;
                    state_nx       = FS_HALT;
                end else if (state_q == FS_RUN) begin
                    if (req_valid && i_stall) begin
                        pend_prio_nx   = req_prio;
                        pend_target_nx = req_target;
                        state_nx       = FS_HOLD;
                    end else if (req_valid) begin
                        issue       = 1'b1;
                        issue_flush = 1'b1;
                    end
                end else begin
                    if (req_valid && prio_wins(req_prio, pend_prio_q)) begin
                        sel_prio   = req_prio;
                        sel_target = req_target;
                    end
                    if (i_stall) begin
                        pend_prio_nx   = sel_prio;
                        pend_target_nx = sel_target;
                    end else begin
                        issue          = 1'b1;
                        issue_flush    = 1'b1;
                        issue_pc       = sel_target;
                        pend_prio_nx   = RS_JMP;
                        pend_target_nx = '0;
                        state_nx       = FS_RUN;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_BOOT;
            boot_cnt_q    <= '0;
            pend_prio_q   <= RS_JMP;
            pend_target_q <= '0;
            o_we          <= 1'b0;
            o_flush       <= 1'b0;
            o_PC          <= RESET_VEC;
        end else begin
            state_q       <= state_nx;
            boot_cnt_q    <= boot_cnt_nx;
            pend_prio_q   <= pend_prio_nx;
            pend_target_q <= pend_target_nx;
            o_we          <= issue;
            o_flush       <= issue_flush;
            if (issue) o_PC <= issue_pc;
        end
    end

    assign o_pause = i_stall || (state_q != FS_RUN);
    assign o_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: every o_we pulse is matched
// against a queue of expected {PC, flush} pairs pushed when stimulus is driven.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_exc_valid = 1'b0;
    logic        i_eret_valid = 1'b0;
    logic [31:0] i_epc = '0;
    logic        i_br_valid = 1'b0;
    logic [31:0] i_br_target = '0;
    logic        i_jmp_valid = 1'b0;
    logic [31:0] i_jmp_target = '0;
    logic        i_halt = 1'b0;
    logic        o_pause, o_we, o_flush;
    logic [31:0] o_PC;
    logic [1:0]  o_state;

    localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_HALT = 2'd3;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .i_stall(i_stall),
        .i_exc_valid(i_exc_valid), .i_eret_valid(i_eret_valid), .i_epc(i_epc),
        .i_br_valid(i_br_valid), .i_br_target(i_br_target),
        .i_jmp_valid(i_jmp_valid), .i_jmp_target(i_jmp_target),
        .i_halt(i_halt), .o_pause(o_pause), .o_we(o_we), .o_PC(o_PC),
        .o_flush(o_flush), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        i_exc_valid = 1'b0; i_eret_valid = 1'b0;
        i_br_valid = 1'b0; i_jmp_valid = 1'b0; i_halt = 1'b0;
    endtask

    always @(negedge clk) begin
        if (o_we) begin
            if (exp_q.size() == 0) chk("spurious_we", {32'h0, o_we}, 33'h0);
            else                   chk("we_pulse", {o_PC, o_flush}, exp_q.pop_front());
        end
    end

    task automatic boot_release();
        exp_q.push_back({32'h0000_3000, 1'b0});
        rst = 1'b0;
        chk("boot_c1_state", {31'h0, o_state}, {31'h0, S_BOOT});
        chk("boot_c1_pause", {32'h0, o_pause}, 33'h1);
        step();
        chk("boot_c2_state", {31'h0, o_state}, {31'h0, S_BOOT});
        chk("boot_c2_pause", {32'h0, o_pause}, 33'h1);
        step();
        chk("boot_c3_run", {31'h0, o_state}, {31'h0, S_RUN});
        chk("boot_c3_pause", {32'h0, o_pause}, 33'h0);
    endtask

    initial begin
        // Test 1: reset values, then boot sequence
        repeat (3) step();
        chk("rst_state", {31'h0, o_state}, {31'h0, S_BOOT});
        chk("rst_we", {32'h0, o_we}, 33'h0);
        chk("rst_flush", {32'h0, o_flush}, 33'h0);
        chk("rst_pause", {32'h0, o_pause}, 33'h1);
        chk("rst_pc", {o_PC, 1'b0}, {32'h0000_3000, 1'b0});
        boot_release();
        step();

        // Test 2: branch redirect, one cycle latency, PC holds afterwards
        i_br_valid = 1'b1; i_br_target = 32'h0000_3040;
        exp_q.push_back({32'h0000_3040, 1'b1});
        step();
        clear_redirects();
        step();
        chk("br_we_drop", {32'h0, o_we}, 33'h0);
        chk("br_pc_hold", {o_PC, 1'b0}, {32'h0000_3040, 1'b0});

        // Test 3: exc + br + jmp in the same cycle
        i_exc_valid = 1'b1; i_br_valid = 1'b1; i_br_target = 32'h0000_3100;
        i_jmp_valid = 1'b1; i_jmp_target = 32'h0000_3200;
        exp_q.push_back({32'h0000_4180, 1'b1});
        step();
        clear_redirects();
        step();

        // eret alone, target passed through unmodified
        i_eret_valid = 1'b1; i_epc = 32'h0000_3abe;
        exp_q.push_back({32'h0000_3abe, 1'b1});
        step();
        clear_redirects();
        step();

        // Test 4: redirects under stall, higher priority overwrites, lower does not
        i_stall = 1'b1;
        i_jmp_valid = 1'b1; i_jmp_target = 32'h0000_3300;
        step();
        clear_redirects();
        chk("stall_hold", {31'h0, o_state}, {31'h0, S_HOLD});
        chk("stall_pause", {32'h0, o_pause}, 33'h1);
        i_br_valid = 1'b1; i_br_target = 32'h0000_3400;
        step();
        clear_redirects();
        i_jmp_valid = 1'b1; i_jmp_target = 32'h0000_3600;
        step();
        clear_redirects();
        chk("stall4_hold", {31'h0, o_state}, {31'h0, S_HOLD});
        step();
        i_stall = 1'b0;
        chk("unstall_pause", {32'h0, o_pause}, 33'h1);
        exp_q.push_back({32'h0000_3400, 1'b1});
        step();
        chk("unstall_run", {31'h0, o_state}, {31'h0, S_RUN});
        step();

        // Test 5: halt beats a same-cycle branch, later redirects ignored
        i_halt = 1'b1; i_br_valid = 1'b1; i_br_target = 32'h0000_3700;
        step();
        clear_redirects();
        chk("halt_state", {31'h0, o_state}, {31'h0, S_HALT});
        i_exc_valid = 1'b1; i_jmp_valid = 1'b1; i_jmp_target = 32'h0000_3800;
        step();
        clear_redirects();
        repeat (3) step();
        chk("halt_stays", {31'h0, o_state}, {31'h0, S_HALT});
        chk("halt_pause", {32'h0, o_pause}, 33'h1);
        chk("halt_we", {32'h0, o_we}, 33'h0);
        rst = 1'b1;
        step();
        chk("halt_rst_boot", {31'h0, o_state}, {31'h0, S_BOOT});
        boot_release();
        step();

        // Exception together with halt: redirect issues, then HALT
        i_exc_valid = 1'b1; i_halt = 1'b1;
        exp_q.push_back({32'h0000_4180, 1'b1});
        step();
        clear_redirects();
        chk("exc_halt_state", {31'h0, o_state}, {31'h0, S_HALT});
        step();
        step();
        rst = 1'b1;
        step();
        boot_release();
        step();

        // Test 6: reset while holding a pending redirect discards it
        i_stall = 1'b1;
        i_br_valid = 1'b1; i_br_target = 32'h0000_3500;
        step();
        clear_redirects();
        chk("t6_hold", {31'h0, o_state}, {31'h0, S_HOLD});
        rst = 1'b1;
        step();
        i_stall = 1'b0;
        chk("t6_boot", {31'h0, o_state}, {31'h0, S_BOOT});
        chk("t6_we", {32'h0, o_we}, 33'h0);
        boot_release();
        repeat (6) step();
        chk("t6_pc", {o_PC, 1'b0}, {32'h0000_3000, 1'b0});

        chk("sb_empty", 33'(exp_q.size()), 33'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
